mux_scan_n: RTL and testbench
=============================

# mux_scan_n

Parametrised N-channel, W-bit registered multiplexer with manual select and automatic round-robin scan. It generalises the fixed 4-to-1, 4-bit combinational mux into a sequential block that can drive time-multiplexed outputs such as seven-segment digit scanning on the SWORD board. A channel one-hot enable and a wrap pulse are provided for downstream display and sequencing logic.

## Interface
- `CH`, 4: number of input channels, ≥2; any value, not only powers of two.
- `W`, 4: data width per channel, ≥1.
- `DIV`, 16: dwell in clock cycles per channel during auto scan, ≥1.
- `SW` (localparam) = max(1, clog2(CH)): select/index width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `din`  in  CH*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
- `mode`  in  1  0 = manual select, 1 = auto scan.
- `sel`  in  SW  manual channel index.
- `hold`  in  1  freezes the auto scan position; ignored in manual mode.
- `dout`  out  W  registered data of the current channel.
- `ch_idx`  out  SW  current channel index.
- `ch_en`  out  CH  one-hot of `ch_idx`.
- `wrap`  out  1  one-cycle pulse when auto scan advances from CH-1 to 0.

## Operation
- Internal state: `ch_idx` register, prescaler `pre` (0..DIV-1), registered outputs, and `mode_q` (previous mode).
- At each edge, compute `nxt`, then register `ch_idx<=nxt`, `dout<=din slice nxt`, and `ch_en<=onehot(nxt)`. These three outputs are always mutually consistent.
- **Manual mode (`mode`=0):**
  - If `sel` < CH, `nxt=sel`.
  - If `sel` ≥ CH, `nxt=ch_idx` (out-of-range select is ignored).
  - `pre` is held at 0. `wrap` is 0.
- **Auto mode (`mode`=1, `hold`=0):**
  - If `pre`==DIV-1: `pre<=0` and `nxt=(ch_idx==CH-1)?0:ch_idx+1`.
  - Otherwise: `pre<=pre+1` and `nxt=ch_idx`.
  - `wrap<=1` only on the CH-1→0 advance.
- **Auto mode with `hold`=1:**
  - `pre` and `ch_idx` are frozen and `wrap<=0`.
  - `dout` still re-samples the current channel every cycle.
  - When `hold` is released, counting resumes from the frozen `pre` value.
- **Mode change, detected via `mode_q`:**
  - On the first auto cycle after manual, `pre` is forced to 0 and scanning starts from the current `ch_idx`; no advance occurs in that cycle.
  - Auto→manual applies the manual rule immediately.
- **DIV=1:** the scan advances every cycle, and `wrap` pulses once every CH cycles.
- **Reset (`rst_n`=0 at an edge)** has priority over every input:
  - `dout`=0, `ch_idx`=0, `ch_en`=1 (bit 0 set), `wrap`=0, `pre`=0, `mode_q`=0.
  - A reset mid-scan aborts the dwell. After release, auto scan restarts at channel 0 with a full DIV dwell.

## Timing
- Latency is one cycle. `din`, `sel`, and `mode` sampled at edge t appear on `dout`, `ch_idx`, and `ch_en` after edge t.
- In auto mode, each channel is presented for exactly DIV cycles, and a full scan period is CH*DIV cycles.
- `wrap` is registered. It is high in the same cycle that `ch_idx` first reads 0 after CH-1.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package `mux_pkg`:
  - `clog2` helper function and `onehot(idx, CH)` function.
  - `MODE_MANUAL`/`MODE_AUTO` constants.
- Sub-module `scan_tick`:
  - Parametrised DIV prescaler with `clr` and `en` inputs and a `tick` output, reusable for other scan blocks.
  - `mux_scan_n` owns the index, data, and enable registers.

## Test plan
Bench parameters: CH=4, W=4, DIV=3; `din`=16'h3210 unless stated.
- **Reset:** `rst_n`=0 for 2 edges with `mode`=1 → `dout`=0, `ch_idx`=0, `ch_en`=4'b0001, `wrap`=0. Outputs stay there until the first edge with `rst_n`=1.
- **Manual:** `mode`=0, `sel`=0,1,2,3, each held 2 cycles → one cycle later `dout`=0,1,2,3 and `ch_en`=0001,0010,0100,1000. A CH=3 build with `sel`=3 → `ch_idx` holds its previous value.
- **Auto scan:** `din`=16'hA5A5, `mode`=1 → `ch_idx` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0…; `dout` alternates 5/A every 3 cycles; `wrap` is high only on the cycles where `ch_idx` returns to 0 (period 12).
- **Hold:** assert `hold` for 10 cycles while `ch_idx`=2 and `pre`=1, and change `din` slice 2 to 4'hF → `ch_idx` stays 2, `dout`=F one cycle after the change, `wrap`=0. After release, the advance to 3 occurs after exactly 2 more cycles.
- **Mode switch:**
  - Manual `sel`=1, then `mode`=1 → `ch_idx`=1 for 3 cycles, then 2.
  - Switch back with `sel`=3 → `ch_idx`=3 after one edge.
- **Mid-scan reset:** pulse `rst_n`=0 for one cycle while `ch_idx`=3 in auto mode → next `ch_idx`=0 and `dout`=0. Scan resumes 0,0,0,1… with no `wrap` pulse caused by the reset.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the scanning multiplexer family: mode encodings,
// a constant-foldable ceil(log2) helper and a one-hot decoder.
package mux_pkg;

  // Widest channel count the one-hot helper can produce.
  localparam int MAX_CH = 256;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // ceil(log2(v)); returns 0 for v <= 1 so callers can clamp to a minimum width.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // One-hot of idx among n channels; out-of-range idx yields all zeros.
  function automatic logic [MAX_CH-1:0] onehot(input int idx, input int n);
    logic [MAX_CH-1:0] r;
    r = '0;
    if (idx >= 0 && idx < n && idx < MAX_CH) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_n_scan_tick.sv
// Dwell prescaler: counts 0..DIV-1 while enabled and flags the last count
// as a tick. clr forces the count to zero and suppresses the tick, which
// lets the owner restart a full dwell without an advance in that cycle.
module scan_tick
  import mux_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Next prescaler value: clear wins, otherwise wrap at DIV-1 while enabled.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
    end
  end

  // Prescaler register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  assign tick = en && !clr && (pre_q == LAST);

endmodule

// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual select and automatic
// round-robin scan. dout, ch_idx and ch_en are all registered from the same
// next index, so they always describe the same channel.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter  int CH  = 4,
  parameter  int W   = 4,
  parameter  int DIV = 16,
  localparam int SW  = (clog2(CH) < 1) ? 1 : clog2(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH*W-1:0] din,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  input  logic          hold,
  output logic [W-1:0]  dout,
  output logic [SW-1:0] ch_idx,
  output logic [CH-1:0] ch_en,
  output logic          wrap
);

  localparam logic [SW-1:0] LAST_CH = SW'(CH - 1);

  logic [W-1:0]  dout_q,   dout_d;
  logic [SW-1:0] ch_idx_q, nxt;
  logic [CH-1:0] ch_en_q,  ch_en_d;
  logic          wrap_q,   wrap_d;
  logic          mode_q;

  logic          auto;
  logic          first_auto;
  logic          tick;
  logic [W-1:0]  ch_data [CH];

  // Unpack the channel bus so the data select is a plain array index.
  for (genvar k = 0; k < CH; k++) begin : g_unpack
    assign ch_data[k] = din[k*W +: W];
  end

  assign auto       = (mode == MODE_AUTO);
  // First auto cycle after manual (or after reset): restart a full dwell.
  assign first_auto = auto && (mode_q == MODE_MANUAL);

  scan_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!auto || first_auto),
    .en    (auto && !hold),
    .tick  (tick)
  );

  // Next channel: manual takes an in-range sel, auto advances on a tick.
  always_comb begin
    nxt    = ch_idx_q;
    wrap_d = 1'b0;
    if (!auto) begin
      if (32'(sel) < CH) nxt = sel;
    end else if (tick) begin
      nxt    = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + SW'(1);
      wrap_d = (ch_idx_q == LAST_CH);
    end
    dout_d  = ch_data[nxt];
    ch_en_d = CH'(onehot(int'(nxt), CH));
  end

  // Output and mode-history registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q   <= '0;
      ch_idx_q <= '0;
      ch_en_q  <= CH'(1);
      wrap_q   <= 1'b0;
      mode_q   <= MODE_MANUAL;
    end else begin
      dout_q   <= dout_d;
      ch_idx_q <= nxt;
      ch_en_q  <= ch_en_d;
      wrap_q   <= wrap_d;
      mode_q   <= mode;
    end
  end

  assign dout   = dout_q;
  assign ch_idx = ch_idx_q;
  assign ch_en  = ch_en_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: a CH=4/W=4/DIV=3 build for the main
// behaviour and a CH=3/W=4/DIV=1 build for out-of-range select and
// every-cycle scanning.
module tb_mux_scan_n;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // CH=4, W=4, DIV=3 instance
  logic [15:0] din;
  logic        mode;
  logic [1:0]  sel;
  logic        hold;
  logic [3:0]  dout;
  logic [1:0]  ch_idx;
  logic [3:0]  ch_en;
  logic        wrap;

  // CH=3, W=4, DIV=1 instance
  logic [11:0] din3;
  logic        mode3;
  logic [1:0]  sel3;
  logic        hold3;
  logic [3:0]  dout3;
  logic [1:0]  ch_idx3;
  logic [2:0]  ch_en3;
  logic        wrap3;

  mux_scan_n #(.CH(4), .W(4), .DIV(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .mode   (mode),
    .sel    (sel),
    .hold   (hold),
    .dout   (dout),
    .ch_idx (ch_idx),
    .ch_en  (ch_en),
    .wrap   (wrap)
  );

  mux_scan_n #(.CH(3), .W(4), .DIV(1)) dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din3),
    .mode   (mode3),
    .sel    (sel3),
    .hold   (hold3),
    .dout   (dout3),
    .ch_idx (ch_idx3),
    .ch_en  (ch_en3),
    .wrap   (wrap3)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full output check of the CH=4 instance against an expected channel.
  task automatic chk4(input string tag, input int e_ch, input logic [3:0] e_dout, input logic e_wrap);
    logic [3:0] e_en;
    e_en = 4'b0001 << e_ch;
    chk({tag, ".ch_idx"}, 32'(ch_idx), 32'(e_ch));
    chk({tag, ".dout"},   32'(dout),   32'(e_dout));
    chk({tag, ".ch_en"},  32'(ch_en),  32'(e_en));
    chk({tag, ".wrap"},   32'(wrap),   32'(e_wrap));
  endtask

  task automatic chk3(input string tag, input int e_ch, input logic e_wrap);
    logic [2:0] e_en;
    e_en = 3'b001 << e_ch;
    chk({tag, ".ch_idx"}, 32'(ch_idx3), 32'(e_ch));
    chk({tag, ".dout"},   32'(dout3),   32'(e_ch));   // din3 slice k holds k
    chk({tag, ".ch_en"},  32'(ch_en3),  32'(e_en));
    chk({tag, ".wrap"},   32'(wrap3),   32'(e_wrap));
  endtask

  // ---------------- driver ----------------
  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] e_ch;
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; hold = 1'b0; din = 16'h3210;
    din3 = 12'h210; mode3 = 1'b0; sel3 = 2'd0; hold3 = 1'b0;

    // Reset: two edges, outputs at reset values throughout
    step();
    chk4("rst_e1", 0, 4'h0, 1'b0);
    step();
    chk4("rst_e2", 0, 4'h0, 1'b0);
    chk3("rst3", 0, 1'b0);

    // Manual select 0..3, each held for two edges
    rst_n = 1'b1; mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      step();
      chk4($sformatf("man%0d_a", k), k, 4'(k), 1'b0);
      step();
      chk4($sformatf("man%0d_b", k), k, 4'(k), 1'b0);
    end

    // Auto scan from channel 0; A5A5 gives 5 on even and A on odd channels
    sel = 2'd0;
    step();
    chk4("pre_auto", 0, 4'h0, 1'b0);
    din = 16'hA5A5; mode = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(2'((i / 3) % 4));
    for (int i = 0; i < 20; i++) begin
      step();
      e_ch = exp_q.pop_front();
      chk4($sformatf("auto%0d", i), int'(e_ch), e_ch[0] ? 4'hA : 4'h5,
           (i > 0) && (i % 12 == 0));
    end

    // Now ch_idx=2 with one dwell cycle used: hold for 10 edges, slice 2 -> F
    hold = 1'b1; din = 16'hAFA5;
    for (int i = 0; i < 10; i++) begin
      step();
      chk4($sformatf("hold%0d", i), 2, 4'hF, 1'b0);
    end
    hold = 1'b0;
    step();
    chk4("rel1", 2, 4'hF, 1'b0);
    step();
    chk4("rel2", 3, 4'hA, 1'b0);

    // Auto -> manual applies immediately
    mode = 1'b0; sel = 2'd1;
    step();
    chk4("sw_man", 1, 4'hA, 1'b0);
    // Manual -> auto: full dwell from channel 1, then advance
    mode = 1'b1;
    step(); chk4("sw_auto0", 1, 4'hA, 1'b0);
    step(); chk4("sw_auto1", 1, 4'hA, 1'b0);
    step(); chk4("sw_auto2", 1, 4'hA, 1'b0);
    step(); chk4("sw_auto3", 2, 4'hF, 1'b0);
    mode = 1'b0; sel = 2'd3;
    step();
    chk4("sw_back", 3, 4'hA, 1'b0);

    // Mid-scan reset while on channel 3 in auto mode
    mode = 1'b1;
    step();
    chk4("mid_pre", 3, 4'hA, 1'b0);
    rst_n = 1'b0;
    step();
    chk4("mid_rst", 0, 4'h0, 1'b0);
    rst_n = 1'b1;
    step(); chk4("mid_r0", 0, 4'h5, 1'b0);
    step(); chk4("mid_r1", 0, 4'h5, 1'b0);
    step(); chk4("mid_r2", 0, 4'h5, 1'b0);
    step(); chk4("mid_r3", 1, 4'hA, 1'b0);

    // CH=3 build: out-of-range select keeps the previous channel
    sel3 = 2'd2;
    step();
    chk3("c3_sel2", 2, 1'b0);
    sel3 = 2'd3;
    step();
    chk3("c3_sel3a", 2, 1'b0);
    step();
    chk3("c3_sel3b", 2, 1'b0);

    // CH=3, DIV=1: advance every cycle, wrap once every 3 cycles
    mode3 = 1'b1;
    step(); chk3("d1_0", 2, 1'b0);
    step(); chk3("d1_1", 0, 1'b1);
    step(); chk3("d1_2", 1, 1'b0);
    step(); chk3("d1_3", 2, 1'b0);
    step(); chk3("d1_4", 0, 1'b1);
    step(); chk3("d1_5", 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
